led_slice_streamer: RTL and testbench
=====================================

LED_SLICE_STREAMER -- requirements
Module: led_slice_streamer

Interface
REQ-001 SHALL have parameter NO_ARM_LED, default 32, LEDs per arm (pixels per slice).
REQ-002 SHALL have parameter NO_DELTA_INTERVALS, default 18, angular slices per revolution.
REQ-003 SHALL have parameter RGB_SIZE, default 8, bits per pixel.
REQ-004 SHALL have parameter CLK_DIV, default 4, system clocks per led_sclk half-period (>=1).
REQ-005 SHALL have derived parameter OUT_DIM = NO_DELTA_INTERVALS*NO_ARM_LED*RGB_SIZE.
REQ-006 clock  input  1  single system clock, rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 frame_in  input  OUT_DIM  polar-ordered frame: slice s, LED l at bits [(s*NO_ARM_LED+l)*RGB_SIZE +: RGB_SIZE].
REQ-009 frame_valid  input  1  level; frame_in stable while high.
REQ-010 angle_tick  input  1  one-cycle pulse, start of next angular slice.
REQ-011 rev_sync  input  1  one-cycle pulse, revolution index (hall sensor).
REQ-012 led_sclk  output  1  serial clock to LED driver.
REQ-013 led_sdata  output  1  serial data, MSB first.
REQ-014 busy  output  1  high while a slice is being shifted.
REQ-015 slice_idx  output  clog2(NO_DELTA_INTERVALS)  slice being/last sent.
REQ-016 overrun  output  1  sticky, tick arrived while busy.

Function
REQ-017 SHALL capture frame_in into a shadow register on the rising edge of frame_valid and set pending.
REQ-018 SHALL copy shadow to the active frame and clear pending only when a slice with slice_idx 0 starts; a mid-revolution frame never tears.
REQ-019 SHALL implement states IDLE, SHIFT, LATCH; IDLE->SHIFT on angle_tick; SHIFT->LATCH after NO_ARM_LED*RGB_SIZE bits; LATCH->IDLE after one led_sclk period with sclk low.
REQ-020 SHALL, in SHIFT, send LED 0 first (centre outward), each pixel MSB first, from active frame slice slice_idx.
REQ-021 SHALL change led_sdata only on led_sclk falling edges (or at SHIFT entry); receiver samples on rising edges; each half-period lasts exactly CLK_DIV clocks.
REQ-022 SHALL assert busy from the cycle after angle_tick until LATCH exits; first sclk rising edge CLK_DIV clocks after SHIFT entry.
REQ-023 SHALL advance slice_idx by one on every accepted tick after the first tick following reset or rev_sync, wrapping NO_DELTA_INTERVALS-1 -> 0.
REQ-024 SHALL, on rev_sync, force the next accepted tick to use slice_idx 0; rev_sync coincident with angle_tick applies to that tick.
REQ-025 SHALL ignore angle_tick while busy and set overrun; overrun clears only on reset.
REQ-026 SHALL, when no frame has ever been captured, shift all-zero pixels.
REQ-027 SHALL hold led_sclk low and led_sdata low in IDLE.

Reset
REQ-028 SHALL, on resetn low, asynchronously set state IDLE, led_sclk 0, led_sdata 0, busy 0, slice_idx 0, overrun 0, pending 0, shadow and active frames 0, bit and divider counters 0.
REQ-029 SHALL abort a slice in progress on reset with no further sclk edges.

Structure
REQ-030 SHALL place state encoding and default parameters in shared package led_pkg.
REQ-031 SHALL use one sub-module sclk_divider (CLK_DIV counter producing rise/fall strobes).

Verification
REQ-032 Frame with slice 0 LED 0 = 8'hA5, tick -> first 8 sdata bits 1,0,1,0,0,1,0,1; 256 sclk rising edges total; busy drops after LATCH.
REQ-033 CLK_DIV=4, tick -> first sclk rise 4 clocks after SHIFT entry; period 8 clocks.
REQ-034 18 ticks spaced > slice time -> slice_idx 0..17 then 0; no overrun.
REQ-035 Tick during busy -> ignored, overrun=1, slice unaffected.
REQ-036 New frame at slice 5 -> slices 6..17 old data; slice 0 onward new data.
REQ-037 resetn low mid-shift -> all outputs 0 immediately; next tick sends slice 0 of zero frame.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED slice streamer.
//   - led_state_t : streamer state encoding (IDLE, SHIFT, LATCH)
//   - DEF_*       : default values for the streamer parameters
//   - width_of()  : index width helper that never returns zero
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } led_state_t;

    localparam int unsigned DEF_NO_ARM_LED         = 32;
    localparam int unsigned DEF_NO_DELTA_INTERVALS = 18;
    localparam int unsigned DEF_RGB_SIZE           = 8;
    localparam int unsigned DEF_CLK_DIV            = 4;

    // A one-entry range still needs a one-bit index.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sclk_divider.sv
// sclk_divider: half-period timer for the LED serial clock.
//   clock  in  system clock
//   resetn in  asynchronous active-low reset
//   en     in  run the divider; while low the counter and phase are held at 0
//   rise   out one-cycle strobe: serial clock should go high now
//   fall   out one-cycle strobe: serial clock should go low now
// Each half period lasts exactly CLK_DIV enabled clocks, so the first strobe
// after en rises is a rise, CLK_DIV clocks later.
module sclk_divider
    import led_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clock,
    input  logic resetn,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = width_of(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          phase;
    logic          half;

    assign half = en && (cnt == LAST);
    assign rise = half && !phase;
    assign fall = half && phase;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_slice_streamer.sv
// led_slice_streamer: streams one angular slice of a polar frame to a serial
// LED driver on every angle tick.
//   clock       in  system clock, rising edge
//   resetn      in  asynchronous active-low reset
//   frame_in    in  polar frame, slice s LED l at [(s*NO_ARM_LED+l)*RGB_SIZE +: RGB_SIZE]
//   frame_valid in  level; frame captured into the shadow copy on its rising edge
//   angle_tick  in  pulse; start the next slice
//   rev_sync    in  pulse; next accepted tick sends slice 0
//   led_sclk    out serial clock, data sampled by the driver on rising edges
//   led_sdata   out serial data, LED 0 first, each pixel MSB first
//   busy        out high while a slice is shifted and latched
//   slice_idx   out slice being / last sent
//   overrun     out sticky; a tick arrived while busy
module led_slice_streamer
    import led_pkg::*;
#(
    parameter  int unsigned NO_ARM_LED         = DEF_NO_ARM_LED,
    parameter  int unsigned NO_DELTA_INTERVALS = DEF_NO_DELTA_INTERVALS,
    parameter  int unsigned RGB_SIZE           = DEF_RGB_SIZE,
    parameter  int unsigned CLK_DIV            = DEF_CLK_DIV,
    localparam int unsigned OUT_DIM            = NO_DELTA_INTERVALS * NO_ARM_LED * RGB_SIZE,
    localparam int unsigned SLICE_W            = width_of(NO_DELTA_INTERVALS)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [OUT_DIM-1:0] frame_in,
    input  logic               frame_valid,
    input  logic               angle_tick,
    input  logic               rev_sync,
    output logic               led_sclk,
    output logic               led_sdata,
    output logic               busy,
    output logic [SLICE_W-1:0] slice_idx,
    output logic               overrun
);

    localparam int unsigned SLICE_BITS = NO_ARM_LED * RGB_SIZE;
    localparam int unsigned BIT_W      = width_of(SLICE_BITS);
    localparam int unsigned POS_W      = width_of(OUT_DIM);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(SLICE_BITS - 1);
    localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(NO_DELTA_INTERVALS - 1);

    led_state_t         state;
    logic [OUT_DIM-1:0] shadow;
    logic [OUT_DIM-1:0] active;
    logic [OUT_DIM-1:0] entry_frame;
    logic               pending;
    logic               restart;
    logic               valid_d;
    logic [BIT_W-1:0]   bit_cnt;
    logic [SLICE_W-1:0] next_slice;
    logic               accept;
    logic               load_new;
    logic               div_en;
    logic               rise;
    logic               fall;

    // Frame bit carrying serial bit b of slice s: LED b/RGB_SIZE, MSB first.
    function automatic logic [POS_W-1:0] bit_pos(input int unsigned s, input int unsigned b);
        int unsigned p;
        p = s * SLICE_BITS + (b / RGB_SIZE) * RGB_SIZE + (RGB_SIZE - 1 - b % RGB_SIZE);
        return POS_W'(p);
    endfunction

    assign div_en = (state != IDLE);

    sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clock  (clock),
        .resetn (resetn),
        .en     (div_en),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        accept = angle_tick && !busy;
        if (rev_sync || restart || slice_idx == LAST_SLICE) begin
            next_slice = '0;
        end else begin
            next_slice = slice_idx + SLICE_W'(1);
        end
        load_new = accept && (next_slice == '0) && pending;
        // The first bit leaves on the same edge that swaps frames, so it is
        // taken from the shadow copy when the swap happens.
        entry_frame = load_new ? shadow : active;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            led_sclk  <= 1'b0;
            led_sdata <= 1'b0;
            busy      <= 1'b0;
            slice_idx <= '0;
            overrun   <= 1'b0;
            pending   <= 1'b0;
            restart   <= 1'b1;
            valid_d   <= 1'b0;
            shadow    <= '0;
            active    <= '0;
            bit_cnt   <= '0;
        end else begin
            valid_d <= frame_valid;
            if (angle_tick && busy) overrun <= 1'b1;
            if (rev_sync) restart <= 1'b1;

            if (load_new) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            // A capture on the swap edge must leave the new frame pending.
            if (frame_valid && !valid_d) begin
                shadow  <= frame_in;
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    led_sclk  <= 1'b0;
                    led_sdata <= 1'b0;
                    if (accept) begin
                        state     <= SHIFT;
                        busy      <= 1'b1;
                        slice_idx <= next_slice;
                        restart   <= 1'b0;
                        bit_cnt   <= '0;
                        led_sdata <= entry_frame[bit_pos(32'(next_slice), 0)];
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        led_sclk <= 1'b1;
                    end else if (fall) begin
                        led_sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state     <= LATCH;
                            led_sdata <= 1'b0;
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            led_sdata <= active[bit_pos(32'(slice_idx), 32'(bit_cnt + BIT_W'(1)))];
                        end
                    end
                end
                LATCH: begin
                    // Divider keeps running with sclk held low; its next fall
                    // marks one full period spent in LATCH.
                    if (fall) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_slice_streamer.sv
// tb_led_slice_streamer: directed sequence with random frames, checked against
// a pixel-array model of frame buffering and slice sequencing.
module tb_led_slice_streamer;

    localparam int NL     = 32;
    localparam int ND     = 18;
    localparam int RS     = 8;
    localparam int CD     = 4;
    localparam int SB     = NL * RS;
    localparam int OD     = ND * NL * RS;
    localparam int SW     = $clog2(ND);
    localparam int BUDGET = 3000;

    logic          clock       = 1'b0;
    logic          resetn      = 1'b0;
    logic [OD-1:0] frame_in    = '0;
    logic          frame_valid = 1'b0;
    logic          angle_tick  = 1'b0;
    logic          rev_sync    = 1'b0;
    logic          led_sclk;
    logic          led_sdata;
    logic          busy;
    logic          overrun;
    logic [SW-1:0] slice_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pixel arrays indexed [slice][led].
    logic [7:0] m_active [ND][NL];
    logic [7:0] m_shadow [ND][NL];
    logic [7:0] m_next   [ND][NL];
    bit         m_pending;
    bit         m_restart;
    bit         m_overrun;
    int         m_idx;

    led_slice_streamer #(
        .NO_ARM_LED         (NL),
        .NO_DELTA_INTERVALS (ND),
        .RGB_SIZE           (RS),
        .CLK_DIV            (CD)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .angle_tick  (angle_tick),
        .rev_sync    (rev_sync),
        .led_sclk    (led_sclk),
        .led_sdata   (led_sdata),
        .busy        (busy),
        .slice_idx   (slice_idx),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < ND; s++)
            for (int l = 0; l < NL; l++) begin
                m_active[s][l] = 8'h00;
                m_shadow[s][l] = 8'h00;
            end
        m_pending = 0;
        m_restart = 1;
        m_overrun = 0;
        m_idx     = 0;
    endtask

    task automatic load_frame(input bit force_a5);
        for (int s = 0; s < ND; s++)
            for (int l = 0; l < NL; l++)
                m_next[s][l] = 8'($urandom);
        if (force_a5) m_next[0][0] = 8'hA5;
        for (int s = 0; s < ND; s++)
            for (int l = 0; l < NL; l++)
                frame_in[(s * NL + l) * RS +: RS] = m_next[s][l];
        frame_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        frame_valid = 1'b0;
        m_shadow  = m_next;
        m_pending = 1;
        @(posedge clock);
        #1;
    endtask

    // Issue one tick (optionally with rev_sync), follow the slice to the end
    // of busy, and compare the serial stream with the model.
    task automatic run_slice(input bit rev, input int inject_at, input string tag,
                             output logic [7:0] fb);
        bit   q_exp[$];
        bit   q_cap[$];
        int   exp_slice, c, rises, first_rise, last_rise, bad_period, glitches, mism, drop;
        logic prev_sclk, prev_sdata, sclk_at_drop;

        if (rev || m_restart) exp_slice = 0;
        else                  exp_slice = (m_idx + 1) % ND;
        m_idx     = exp_slice;
        m_restart = 0;
        if (exp_slice == 0 && m_pending) begin
            m_active  = m_shadow;
            m_pending = 0;
        end
        for (int l = 0; l < NL; l++)
            for (int b = RS - 1; b >= 0; b--)
                q_exp.push_back(m_active[exp_slice][l][b]);

        angle_tick = 1'b1;
        rev_sync   = rev;
        @(posedge clock);
        #1;
        angle_tick = 1'b0;
        rev_sync   = 1'b0;
        chk({tag, "/busy_start"}, busy, 1);
        chk({tag, "/slice_idx"}, slice_idx, exp_slice);
        chk({tag, "/sclk_start"}, led_sclk, 0);

        prev_sclk  = led_sclk;
        prev_sdata = led_sdata;
        c = 0; rises = 0; first_rise = -1; last_rise = 0;
        bad_period = 0; glitches = 0; drop = -1; sclk_at_drop = 1'bx;
        while (c < BUDGET) begin
            @(posedge clock);
            #1;
            c++;
            angle_tick = (c == inject_at);
            if (c == inject_at) m_overrun = 1;
            if (!prev_sclk && led_sclk) begin
                rises++;
                q_cap.push_back(led_sdata);
                if (first_rise < 0) first_rise = c;
                else if (c - last_rise != 2 * CD) bad_period++;
                last_rise = c;
            end
            if (led_sdata !== prev_sdata && !(prev_sclk && !led_sclk)) glitches++;
            prev_sclk  = led_sclk;
            prev_sdata = led_sdata;
            if (!busy) begin
                drop         = c;
                sclk_at_drop = led_sclk;
                break;
            end
        end
        angle_tick = 1'b0;

        mism = 0;
        for (int i = 0; i < q_cap.size() && i < q_exp.size(); i++)
            if (q_cap[i] !== q_exp[i]) mism++;
        fb = 8'h00;
        for (int i = 0; i < 8 && i < q_cap.size(); i++)
            fb = {fb[6:0], q_cap[i]};

        chk({tag, "/busy_drop_cycle"}, drop, 2 * CD * (SB + 1));
        chk({tag, "/sclk_low_at_end"}, sclk_at_drop, 0);
        chk({tag, "/rise_count"}, rises, SB);
        chk({tag, "/first_rise"}, first_rise, CD);
        chk({tag, "/bad_periods"}, bad_period, 0);
        chk({tag, "/sdata_glitches"}, glitches, 0);
        chk({tag, "/bit_mismatches"}, mism, 0);
        chk({tag, "/slice_idx_end"}, slice_idx, exp_slice);
        chk({tag, "/overrun"}, overrun, m_overrun);

        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] fb;
        int         highs;

        model_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset/sclk", led_sclk, 0);
        chk("reset/sdata", led_sdata, 0);
        chk("reset/busy", busy, 0);
        chk("reset/slice_idx", slice_idx, 0);
        chk("reset/overrun", overrun, 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // No frame captured yet: slice 0 of an all-zero frame.
        run_slice(0, 0, "zero_frame", fb);

        // Frame A, rev_sync on its own, then slice 0 carrying A.
        load_frame(1);
        rev_sync = 1'b1;
        @(posedge clock);
        #1;
        rev_sync  = 1'b0;
        m_restart = 1;
        run_slice(0, 0, "slice0_a", fb);
        chk("slice0_a/first_byte_a5", fb, 8'hA5);

        // Full revolution; frame B arrives after slice 5 and must wait for slice 0.
        for (int k = 1; k < ND; k++) begin
            run_slice(0, 0, $sformatf("sweep%0d", k), fb);
            if (k == 5) load_frame(0);
        end
        run_slice(0, 0, "wrap_b", fb);
        chk("wrap_b/no_overrun", overrun, 0);

        // Tick mid-shift is ignored and latches overrun.
        run_slice(0, 100, "overrun_slice", fb);

        // rev_sync together with the tick forces slice 0.
        run_slice(1, 0, "rev_with_tick", fb);

        // Reset in the middle of a slice.
        angle_tick = 1'b1;
        @(posedge clock);
        #1;
        angle_tick = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        chk("pre_reset/busy", busy, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_reset/sclk", led_sclk, 0);
        chk("mid_reset/sdata", led_sdata, 0);
        chk("mid_reset/busy", busy, 0);
        chk("mid_reset/slice_idx", slice_idx, 0);
        chk("mid_reset/overrun", overrun, 0);
        highs = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (led_sclk !== 1'b0) highs++;
        end
        chk("mid_reset/no_sclk", highs, 0);
        resetn = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        run_slice(0, 0, "post_reset", fb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
